systemizer_host_ctrl: RTL and testbench

- Host-side controller for the systemizer: the other end of its memory-load and start/status interface.
- Streams an L x K matrix into systemizer memory and runs the left (pivot) pass, then the right pass.
- On success, streams the systematic right part (public-key words) out.
- On early-abort fail, pulses a retry request and re-accepts a fresh matrix.

---
 rtl/systemizer_host_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_systemizer_host_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systemizer_host_ctrl.sv
// Host-side controller for the systemizer: loads an L x K matrix, sequences the
// left and right passes, retries on early-abort fail and streams the public-key words out.
module systemizer_host_ctrl #(
  parameter int unsigned M  = 1,
  parameter int unsigned N  = 20,
  parameter int unsigned L  = 200,
  parameter int unsigned K  = 400,
  parameter int unsigned AW = $clog2(L * K / N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*M-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*M-1:0] out_data,
  output logic           out_last,
  output logic           busy,
  output logic           retry,
  output logic           job_done,
  output logic           sys_start,
  output logic           sys_start_right,
  input  logic           sys_success,
  input  logic           sys_fail,
  input  logic           sys_done,
  output logic           sys_wr_en,
  output logic [AW-1:0]  sys_wr_addr,
  output logic [N*M-1:0] sys_data_in,
  output logic           sys_rd_en,
  output logic [AW-1:0]  sys_rd_addr,
  input  logic [N*M-1:0] sys_data_out
);

  localparam int unsigned DW     = N * M;
  localparam int unsigned Words  = L * K / N;
  localparam int unsigned RBase  = L * L / N;
  localparam int unsigned RWords = Words - RBase;

  // One extra bit so the read pointer can rest at Words even when Words is a power of two.
  typedef logic [AW:0] cnt_t;
  localparam cnt_t WordsC = cnt_t'(Words);
  localparam cnt_t WLastC = cnt_t'(Words - 1);
  localparam cnt_t RBaseC = cnt_t'(RBase);
  localparam cnt_t RLastC = cnt_t'(RWords - 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StStartL, StWaitL, StStartR, StWaitR, StUnload, StDone
  } state_e;

  state_e        state_q, state_d;
  cnt_t          wr_ptr_q, wr_ptr_d;
  cnt_t          rd_ptr_q, rd_ptr_d;
  cnt_t          sent_q, sent_d;
  logic          retry_q, retry_d;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;
  logic          inflight_q;
  logic [DW-1:0] fifo_q [2];
  logic          fifo_wptr_q, fifo_rptr_q;
  logic [1:0]    fifo_cnt_q;
  logic [1:0]    occ;
  logic          pop, rd_en, wr_hs;

  assign out_valid   = (fifo_cnt_q != 2'd0);
  assign pop         = out_valid & out_ready;
  assign out_data    = fifo_q[fifo_rptr_q];
  assign out_last    = out_valid && (sent_q == RLastC);
  assign wr_hs       = in_valid & in_ready;
  // Credit the pop this cycle so a drained FIFO can sustain one word per cycle.
  assign occ         = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
  assign retry       = retry_q;
  assign sys_wr_en   = wr_en_q;
  assign sys_wr_addr = wr_addr_q;
  assign sys_data_in = wr_data_q;
  assign sys_rd_en   = rd_en;
  assign sys_rd_addr = rd_ptr_q[AW-1:0];

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    sent_d          = sent_q;
    retry_d         = 1'b0;
    in_ready        = 1'b0;
    sys_start       = 1'b0;
    sys_start_right = 1'b0;
    job_done        = 1'b0;
    busy            = 1'b1;
    rd_en           = 1'b0;
    case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (go) begin
          state_d  = StLoad;
          wr_ptr_d = '0;
        end
      end
      StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (wr_ptr_q == WLastC) begin
            state_d = StStartL;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      StStartL: begin
        sys_start = 1'b1;
        state_d   = StWaitL;
      end
      StWaitL: begin
        // Fail wins when both flags arrive together.
        if (sys_fail) begin
          retry_d  = 1'b1;
          wr_ptr_d = '0;
          state_d  = StLoad;
        end else if (sys_success) begin
          state_d = StStartR;
        end
      end
      StStartR: begin
        sys_start_right = 1'b1;
        state_d         = StWaitR;
      end
      StWaitR: begin
        if (sys_done) begin
          rd_ptr_d = RBaseC;
          sent_d   = '0;
          state_d  = StUnload;
        end
      end
      StUnload: begin
        rd_en = (rd_ptr_q < WordsC) && (occ < 2'd2);
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        if (pop) begin
          sent_d = sent_q + 1'b1;
          if (sent_q == RLastC) state_d = StDone;
        end
      end
      StDone: begin
        job_done = 1'b1;
        busy     = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      sent_q   <= '0;
      retry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sent_q   <= sent_d;
      retry_q  <= retry_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= wr_hs;
      if (wr_hs) begin
        wr_addr_q <= wr_ptr_q[AW-1:0];
        wr_data_q <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q  <= 1'b0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      fifo_wptr_q <= 1'b0;
      fifo_rptr_q <= 1'b0;
      fifo_cnt_q  <= 2'd0;
    end else begin
      inflight_q <= rd_en;
      if (inflight_q) begin
        fifo_q[fifo_wptr_q] <= sys_data_out;
        fifo_wptr_q         <= ~fifo_wptr_q;
      end
      if (pop) fifo_rptr_q <= ~fifo_rptr_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_systemizer_host_ctrl.sv
// Scoreboard bench for systemizer_host_ctrl: directed jobs, fail/retry, stalls and resets.
module tb_systemizer_host_ctrl;
  localparam int unsigned M = 2, N = 4, L = 8, K = 16, AW = 5, DW = 8;
  localparam int unsigned Words = 32, RBase = 16, RWords = 16;

  logic clk = 1'b0, rst = 1'b1, go = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic sys_success = 1'b0, sys_fail = 1'b0, sys_done = 1'b0;
  logic [DW-1:0] in_data = '0, sys_data_out = '0;
  logic in_ready, out_valid, out_last, busy, retry, job_done, sys_start, sys_start_right;
  logic sys_wr_en, sys_rd_en;
  logic [DW-1:0] out_data, sys_data_in;
  logic [AW-1:0] sys_wr_addr, sys_rd_addr;

  systemizer_host_ctrl #(.M(M), .N(N), .L(L), .K(K)) dut (
    .clk(clk), .rst(rst), .go(go), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .retry(retry), .job_done(job_done),
    .sys_start(sys_start), .sys_start_right(sys_start_right), .sys_success(sys_success),
    .sys_fail(sys_fail), .sys_done(sys_done), .sys_wr_en(sys_wr_en),
    .sys_wr_addr(sys_wr_addr), .sys_data_in(sys_data_in), .sys_rd_en(sys_rd_en),
    .sys_rd_addr(sys_rd_addr), .sys_data_out(sys_data_out)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct packed { logic [DW-1:0] data; logic last; } out_t;
  wr_t  wr_q[$];
  out_t out_q[$];

  int n_vec = 0, n_bad = 0, cyc = 0;
  int start_cnt = 0, startr_cnt = 0, retry_cnt = 0, done_cnt = 0, pop_cnt = 0;
  int first_pop_cyc = 0, last_pop_cyc = 0, done_cyc = 0, first_seen = 0;
  int rd_tot = 0, pop_tot = 0, max_out = 0, overlap_cnt = 0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  // Systemizer memory model: the right part reads back as a fixed function of address.
  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return 8'({3'b000, a} * 8'd7 + 8'd3);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) sys_data_out <= sys_rd_en ? mem_val(sys_rd_addr) : 8'hEE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected writes and output words as the DUT presents them.
  always @(negedge clk) begin
    wr_t  w;
    out_t o;
    if (sys_wr_en && sys_rd_en) overlap_cnt++;
    if (sys_wr_en) begin
      check("write_expected", 32'(wr_q.size() > 0), 1);
      if (wr_q.size() > 0) begin
        w = wr_q.pop_front();
        check("wr_addr", 32'(sys_wr_addr), 32'(w.addr));
        check("wr_data", 32'(sys_data_in), 32'(w.data));
      end
    end
    if (sys_start) start_cnt++;
    if (sys_start_right) startr_cnt++;
    if (retry) retry_cnt++;
    if (job_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!rst) begin
      prev_stall = 1'b0;
      rd_tot = 0;
      pop_tot = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 1);
        check("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        check("output_expected", 32'(out_q.size() > 0), 1);
        if (out_q.size() > 0) begin
          o = out_q.pop_front();
          check("out_data", 32'(out_data), 32'(o.data));
          check("out_last", 32'(out_last), 32'(o.last));
        end
        if (first_seen == 0) first_pop_cyc = cyc;
        first_seen = 1;
        last_pop_cyc = cyc;
        pop_cnt++;
      end
      rd_tot += int'(sys_rd_en);
      pop_tot += int'(out_valid && out_ready);
      if (rd_tot - pop_tot > max_out) max_out = rd_tot - pop_tot;
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cnt_of(input int sel);
    case (sel)
      0: return start_cnt;
      1: return startr_cnt;
      default: return pop_cnt;
    endcase
  endfunction

  task automatic wait_evt(input int sel, input int base, input int need, input int limit);
    for (int t = 0; t < limit && (cnt_of(sel) - base) < need; t++) tick();
  endtask

  task automatic check_quiet(input string name);
    check({name, "_ctrl"}, 32'({in_ready, out_valid, out_last, busy, retry, job_done, sys_start,
                                sys_start_right, sys_wr_en, sys_rd_en}), 0);
    check({name, "_bus"}, 32'({sys_wr_addr, sys_rd_addr, out_data, sys_data_in}), 0);
  endtask

  task automatic load_matrix(input int base, input bit gaps, input bit go_mid);
    wr_t w;
    for (int i = 0; i < int'(Words); i++) begin
      if (gaps) while ($urandom_range(0, 2) == 0) begin in_valid = 1'b0; tick(); end
      in_valid = 1'b1;
      in_data  = 8'(base + i);
      if (go_mid && i == 5) go = 1'b1;
      for (int t = 0; t < 50 && !in_ready; t++) tick();
      w.addr = 5'(i);
      w.data = 8'(base + i);
      wr_q.push_back(w);
      tick();
      go = 1'b0;
    end
    in_valid = 1'b0;
    check("in_ready_drop", 32'(in_ready), 0);
  endtask

  task automatic start_left(input int base, input bit gaps, input bit go_mid);
    int s0;
    s0 = start_cnt;
    load_matrix(base, gaps, go_mid);
    wait_evt(0, s0, 1, 5);
    tick(); tick();
    check("start_once", 32'(start_cnt - s0), 1);
  endtask

  // fail_mode: 0 none, 1 sys_fail, 2 sys_fail with sys_success
  task automatic run_job(input int base, input bit gaps, input int fail_mode, input bit stall,
                         input bit abort_unload);
    int sr0, r0, d0, p0, done_req_cyc;
    out_t o;
    go = 1'b1; tick(); go = 1'b0;
    check("busy_after_go", 32'(busy), 1);
    check("in_ready_load", 32'(in_ready), 1);
    start_left(base, gaps, gaps);
    if (fail_mode != 0) begin
      r0 = retry_cnt;
      sys_fail = 1'b1;
      sys_success = (fail_mode == 2);
      tick();
      sys_fail = 1'b0; sys_success = 1'b0;
      tick();
      check("retry_once", 32'(retry_cnt - r0), 1);
      check("in_ready_reload", 32'(in_ready), 1);
      start_left(base + 64, 1'b0, 1'b0);
    end
    if (gaps) begin go = 1'b1; tick(); go = 1'b0; end
    sr0 = startr_cnt;
    sys_success = 1'b1; tick(); sys_success = 1'b0;
    wait_evt(1, sr0, 1, 5);
    tick(); tick();
    check("start_right_once", 32'(startr_cnt - sr0), 1);
    for (int j = 0; j < int'(RWords); j++) begin
      o.data = mem_val(5'(RBase + j));
      o.last = (j == int'(RWords) - 1);
      out_q.push_back(o);
    end
    first_seen = 0; max_out = 0; d0 = done_cnt; p0 = pop_cnt;
    out_ready = 1'b1;
    sys_done = 1'b1; done_req_cyc = cyc; tick(); sys_done = 1'b0;
    if (abort_unload) begin
      wait_evt(2, p0, 5, 50);
      #1 rst = 1'b0;
      #1 check_quiet("reset_unload");
      out_q.delete();
      tick(); tick();
      rst = 1'b1;
      tick();
      check("busy_after_reset", 32'(busy), 0);
    end else begin
      for (int t = 0; t < 300 && done_cnt == d0; t++) begin
        if (stall) out_ready = 1'($urandom_range(0, 1));
        tick();
      end
      check("job_done_once", 32'(done_cnt - d0), 1);
      check("outq_drained", 32'(out_q.size()), 0);
      check("max_outstanding_le2", 32'(max_out <= 2), 1);
      check("done_after_last", 32'(done_cyc - last_pop_cyc), 1);
      if (!stall) begin
        check("first_latency", 32'(first_pop_cyc - done_req_cyc), 3);
        check("sustained_rate", 32'(last_pop_cyc - first_pop_cyc), int'(RWords) - 1);
      end
      tick();
      check("busy_idle", 32'(busy), 0);
    end
    out_ready = 1'b0;
  endtask

  task automatic reset_mid_load();
    wr_t w;
    go = 1'b1; tick(); go = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data = 8'(8'hC0 + i);
      w.addr = 5'(i);
      w.data = 8'(8'hC0 + i);
      wr_q.push_back(w);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    check("writes_before_reset", 32'(wr_q.size()), 0);
    in_valid = 1'b1; in_data = 8'hCA;
    #1 rst = 1'b0;
    #1 check_quiet("reset_load");
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    check("idle_after_reset", 32'({busy, in_ready}), 0);
  endtask

  initial begin
    #1 rst = 1'b0;
    tick(); tick();
    check_quiet("reset");
    rst = 1'b1;
    tick();
    run_job(0, 1'b0, 0, 1'b0, 1'b0);
    run_job(8'h40, 1'b1, 0, 1'b1, 1'b0);
    run_job(8'h10, 1'b0, 1, 1'b0, 1'b0);
    run_job(8'h20, 1'b0, 2, 1'b1, 1'b0);
    reset_mid_load();
    run_job(8'h50, 1'b0, 0, 1'b0, 1'b1);
    run_job(8'h90, 1'b0, 0, 1'b0, 1'b0);
    check("rd_wr_overlap", 32'(overlap_cnt), 0);
    check("wrq_drained", 32'(wr_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected bench completion");
    $fatal(1);
  end

endmodule
